// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory port arbiter.
package mem_arb_pkg;

   localparam int ADDR_W_DEF = 4;
   localparam int WORD_W_DEF = 32;
   localparam int RD_LAT_DEF = 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   typedef enum logic {PORT_I, PORT_D} port_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker. Bit 0 is the fetch port, bit 1 is the data port.
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  port_t      pointer,
   input  logic       advance,
   output logic [1:0] grant,
   output port_t      pointer_nxt
);

   always_comb begin
      grant       = req;
      pointer_nxt = pointer;
      if (req == 2'b11) begin
         grant = (pointer == PORT_I) ? 2'b01 : 2'b10;
      end
      // After a grant the other port gets priority next time.
      if (advance && grant[0]) begin
         pointer_nxt = PORT_D;
      end else if (advance && grant[1]) begin
         pointer_nxt = PORT_I;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store accesses onto the single-port memory.
//   state | meaning
//   IDLE  | waiting for a request; winner granted combinationally
//   ISSUE | one memory strobe cycle from the latched request
//   WAIT  | read latency beyond the first cycle
//   RESP  | read data returned to the winning port
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_W_DEF,
   parameter int WORD_WIDTH = WORD_W_DEF,
   parameter int RD_LATENCY = RD_LAT_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic                  if_gnt,
   output logic                  if_rvalid,
   output logic [WORD_WIDTH-1:0] if_rdata,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [WORD_WIDTH-1:0] d_wdata,
   output logic                  d_gnt,
   output logic                  d_rvalid,
   output logic [WORD_WIDTH-1:0] d_rdata,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [WORD_WIDTH-1:0] mem_data_in,
   input  logic [WORD_WIDTH-1:0] mem_data_out
);

   localparam int CNT_W = 2;
   localparam logic [CNT_W-1:0] WAIT_LOAD =
      (RD_LATENCY > 1) ? CNT_W'(RD_LATENCY - 2) : '0;

   state_t                state, state_nxt;
   port_t                 ptr, ptr_nxt;
   port_t                 lat_port;
   logic                  lat_we;
   logic [ADDR_WIDTH-1:0] lat_addr;
   logic [WORD_WIDTH-1:0] lat_wdata;
   logic [CNT_W-1:0]      wait_cnt;
   logic [1:0]            arb_gnt;
   logic                  arb_adv;

   rr_arb2 u_rr_arb2 (
      .req         ({d_req, if_req}),
      .pointer     (ptr),
      .advance     (arb_adv),
      .grant       (arb_gnt),
      .pointer_nxt (ptr_nxt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= PORT_I;
         lat_port  <= PORT_I;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         wait_cnt  <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
         if (state == IDLE && arb_gnt[0]) begin
            lat_port <= PORT_I;
            lat_we   <= 1'b0;
            lat_addr <= if_addr;
         end else if (state == IDLE && arb_gnt[1]) begin
            lat_port <= PORT_D;
            lat_we   <= d_we;
            lat_addr <= d_addr;
            if (d_we) begin
               lat_wdata <= d_wdata;
            end
         end
         // Down-counter: WAIT ends on terminal count zero.
         if (state == ISSUE) begin
            wait_cnt <= WAIT_LOAD;
         end else if (state == WAIT && wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      arb_adv   = 1'b0;
      if_gnt    = 1'b0;
      d_gnt     = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      if_rvalid = 1'b0;
      d_rvalid  = 1'b0;
      case (state)
         IDLE: begin
            arb_adv = 1'b1;
            if_gnt  = arb_gnt[0];
            d_gnt   = arb_gnt[1];
            if (|arb_gnt) begin
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            if (lat_we) begin
               mem_write = 1'b1;
               state_nxt = IDLE;
            end else begin
               mem_read  = 1'b1;
               state_nxt = (RD_LATENCY > 1) ? WAIT : RESP;
            end
         end
         WAIT: begin
            if (wait_cnt == '0) begin
               state_nxt = RESP;
            end
         end
         RESP: begin
            if_rvalid = (lat_port == PORT_I);
            d_rvalid  = (lat_port == PORT_D);
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign mem_address = lat_addr;
   assign mem_data_in = lat_wdata;
   assign if_rdata    = if_rvalid ? mem_data_out : '0;
   assign d_rdata     = d_rvalid ? mem_data_out : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: one arbiter with 1-cycle memory, one with 3-cycle memory.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n, rst3_n;
   int          checks = 0;
   int          errors = 0;

   logic        if_req, if_gnt, if_rvalid, d_req, d_we, d_gnt, d_rvalid;
   logic [3:0]  if_addr, d_addr, mem_address;
   logic [31:0] if_rdata, d_wdata, d_rdata, mem_data_in, mem_data_out;
   logic        mem_read, mem_write;

   logic        if_req3, if_gnt3, if_rvalid3, d_req3, d_we3, d_gnt3, d_rvalid3;
   logic [3:0]  if_addr3, d_addr3, mem_address3;
   logic [31:0] if_rdata3, d_wdata3, d_rdata3, mem_data_in3, mem_data_out3;
   logic        mem_read3, mem_write3;

   logic [31:0] mem_a [16];
   logic [31:0] mem_b [16];
   logic [31:0] rd_a;
   logic [31:0] p3 [3];

   int          viol = 0, gnt_cnt = 0, iss_cnt = 0, stray = 0;
   logic        last_i = 1'b0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_WIDTH(4), .WORD_WIDTH(32), .RD_LATENCY(1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
      .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_data_in(mem_data_in), .mem_data_out(mem_data_out));

   mem_port_arbiter #(.ADDR_WIDTH(4), .WORD_WIDTH(32), .RD_LATENCY(3)) dut3 (
      .clk(clk), .rst_n(rst3_n),
      .if_req(if_req3), .if_addr(if_addr3), .if_gnt(if_gnt3), .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
      .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3), .d_gnt(d_gnt3),
      .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
      .mem_read(mem_read3), .mem_write(mem_write3), .mem_address(mem_address3),
      .mem_data_in(mem_data_in3), .mem_data_out(mem_data_out3));

   // Memory models: word i initialised to 0xA000_0000 + i.
   initial begin
      for (int i = 0; i < 16; i++) begin
         mem_a[i] = 32'hA000_0000 + i;
         mem_b[i] = 32'hA000_0000 + i;
      end
   end

   always @(posedge clk) begin
      if (mem_write) mem_a[mem_address] <= mem_data_in;
      rd_a <= mem_a[mem_address];
      if (mem_write3) mem_b[mem_address3] <= mem_data_in3;
      p3[0] <= mem_b[mem_address3];
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end
   assign mem_data_out  = rd_a;
   assign mem_data_out3 = p3[2];

   // Invariant monitor on the 1-cycle instance.
   always @(negedge clk) begin
      if (mem_read && mem_write) viol++;
      if (if_gnt || d_gnt) gnt_cnt++;
      if (mem_read || mem_write) iss_cnt++;
      if (mem_write && last_i) viol++;
      if (if_gnt) last_i = 1'b1;
      else if (d_gnt) last_i = 1'b0;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; rst3_n = 1'b0;
      if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
      if_req3 = 1'b0; if_addr3 = '0; d_req3 = 1'b0; d_we3 = 1'b0; d_addr3 = '0; d_wdata3 = '0;
      #3;
      chk1("rst_mem_read", mem_read, 1'b0);
      chk1("rst_mem_write", mem_write, 1'b0);
      chk32("rst_mem_address", 32'(mem_address), 32'h0);
      chk32("rst_mem_data_in", mem_data_in, 32'h0);
      step(); step();
      rst_n = 1'b1; rst3_n = 1'b1;
      step();

      // Fetch read of word 0
      if_req = 1'b1; if_addr = 4'h0;
      #1;
      chk1("fetch_if_gnt_c0", if_gnt, 1'b1);
      chk1("fetch_d_gnt_c0", d_gnt, 1'b0);
      step(); if_req = 1'b0;
      chk1("fetch_mem_read_c1", mem_read, 1'b1);
      chk1("fetch_mem_write_c1", mem_write, 1'b0);
      chk32("fetch_addr_c1", 32'(mem_address), 32'h0);
      chk1("fetch_rvalid_early", if_rvalid, 1'b0);
      step();
      chk1("fetch_if_rvalid_c2", if_rvalid, 1'b1);
      chk32("fetch_if_rdata_c2", if_rdata, 32'hA000_0000);
      chk1("fetch_mem_read_c2", mem_read, 1'b0);
      step();
      chk1("fetch_if_rvalid_c3", if_rvalid, 1'b0);

      // Write 1 to address 3, then read back
      d_req = 1'b1; d_we = 1'b1; d_addr = 4'h3; d_wdata = 32'h1;
      #1;
      chk1("wr_d_gnt_c0", d_gnt, 1'b1);
      step(); d_req = 1'b0; d_wdata = 32'h55;
      chk1("wr_mem_write_c1", mem_write, 1'b1);
      chk1("wr_mem_read_c1", mem_read, 1'b0);
      chk32("wr_addr_c1", 32'(mem_address), 32'h3);
      chk32("wr_data_c1", mem_data_in, 32'h1);
      step();
      chk1("wr_mem_write_c2", mem_write, 1'b0);
      chk1("wr_d_rvalid_c2", d_rvalid, 1'b0);
      chk32("wr_addr_hold", 32'(mem_address), 32'h3);
      d_req = 1'b1; d_we = 1'b0; d_addr = 4'h3;
      #1;
      chk1("rd_d_gnt_c0", d_gnt, 1'b1);
      step(); d_req = 1'b0;
      chk1("rd_mem_read_c1", mem_read, 1'b1);
      step();
      chk1("rd_d_rvalid_c2", d_rvalid, 1'b1);
      chk32("rd_d_rdata_c2", d_rdata, 32'h0000_0001);
      chk1("rd_if_rvalid_c2", if_rvalid, 1'b0);
      step();

      // Contention: both held, expect I, D, I
      if_req = 1'b1; if_addr = 4'h5; d_req = 1'b1; d_we = 1'b0; d_addr = 4'h6;
      #1;
      chk1("ct1_if_gnt", if_gnt, 1'b1);
      chk1("ct1_d_gnt", d_gnt, 1'b0);
      step();
      chk1("ct1_busy_d_gnt", d_gnt, 1'b0);
      chk1("ct1_busy_if_gnt", if_gnt, 1'b0);
      chk32("ct1_addr", 32'(mem_address), 32'h5);
      step();
      chk1("ct1_if_rvalid", if_rvalid, 1'b1);
      chk32("ct1_if_rdata", if_rdata, 32'hA000_0005);
      chk1("ct1_resp_d_gnt", d_gnt, 1'b0);
      step();
      chk1("ct2_d_gnt", d_gnt, 1'b1);
      chk1("ct2_if_gnt", if_gnt, 1'b0);
      step();
      chk1("ct2_busy_if_gnt", if_gnt, 1'b0);
      chk32("ct2_addr", 32'(mem_address), 32'h6);
      step();
      chk1("ct2_d_rvalid", d_rvalid, 1'b1);
      chk32("ct2_d_rdata", d_rdata, 32'hA000_0006);
      step();
      chk1("ct3_if_gnt", if_gnt, 1'b1);
      chk1("ct3_d_gnt", d_gnt, 1'b0);
      step(); if_req = 1'b0; d_req = 1'b0;
      step(); step();

      // RD_LATENCY=3: data read of 0xA
      d_req3 = 1'b1; d_we3 = 1'b0; d_addr3 = 4'hA;
      #1;
      chk1("l3_d_gnt_c0", d_gnt3, 1'b1);
      step(); d_req3 = 1'b0;
      chk1("l3_mem_read_c1", mem_read3, 1'b1);
      step();
      chk1("l3_mem_read_c2", mem_read3, 1'b0);
      chk1("l3_rvalid_c2", d_rvalid3, 1'b0);
      step();
      chk1("l3_rvalid_c3", d_rvalid3, 1'b0);
      step();
      chk1("l3_rvalid_c4", d_rvalid3, 1'b1);
      chk32("l3_rdata_c4", d_rdata3, 32'hA000_000A);
      step();
      chk1("l3_rvalid_c5", d_rvalid3, 1'b0);

      // Fetch read on latency-3 instance, reset while in WAIT
      if_req3 = 1'b1; if_addr3 = 4'h2;
      #1;
      chk1("rs_if_gnt3", if_gnt3, 1'b1);
      step(); if_req3 = 1'b0;
      chk1("rs_mem_read3", mem_read3, 1'b1);
      step();
      rst3_n = 1'b0;
      #1;
      chk1("rs_mem_read3_low", mem_read3, 1'b0);
      chk1("rs_mem_write3_low", mem_write3, 1'b0);
      chk1("rs_if_rvalid3_low", if_rvalid3, 1'b0);
      chk32("rs_addr3_zero", 32'(mem_address3), 32'h0);
      step(); step();
      rst3_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         if (if_rvalid3 || d_rvalid3 || mem_read3 || mem_write3) stray++;
      end
      chk32("rs_no_activity", 32'(stray), 32'h0);
      if_req3 = 1'b1; d_req3 = 1'b1; d_we3 = 1'b0;
      #1;
      chk1("rs_ptr_if_gnt3", if_gnt3, 1'b1);
      chk1("rs_ptr_d_gnt3", d_gnt3, 1'b0);
      step(); if_req3 = 1'b0; d_req3 = 1'b0;

      // Random traffic on the 1-cycle instance
      for (int i = 0; i < 200; i++) begin
         step();
         if_req  = 1'($urandom_range(0, 1));
         if_addr = 4'($urandom);
         d_req   = 1'($urandom_range(0, 1));
         d_we    = 1'($urandom_range(0, 1));
         d_addr  = 4'($urandom);
         d_wdata = 32'h0000_FFFF;
      end
      step();
      if_req = 1'b0; d_req = 1'b0;
      for (int i = 0; i < 5; i++) step();
      chk32("inv_violations", 32'(viol), 32'h0);
      chk32("inv_gnt_vs_issue", 32'(iss_cnt), 32'(gnt_cnt));
      chk1("inv_traffic_seen", gnt_cnt > 20, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port `memory` block.
- Port I is instruction fetch (read-only); port D is load/store (read/write).
- Serialises accesses, never drives memRead and memWrite together, and returns read data to the winning requester.
- Sits between the core's fetch/LSU front ends and the `memory` instance.

Parameters:
- ADDR_WIDTH, 4, memory address width; must equal the memory's ADDR_WIDTH.
- WORD_WIDTH, 32, data word width; must equal the memory's WORD_WIDTH.
- RD_LATENCY, 1, memory read latency in cycles from the memRead cycle to valid data_out; legal range 1..4.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; held until if_gnt.
- if_addr  in  ADDR_WIDTH  fetch address.
- if_gnt  out  1  fetch request accepted (1-cycle pulse).
- if_rvalid  out  1  fetch read data valid (1-cycle pulse).
- if_rdata  out  WORD_WIDTH  fetch read data.
- d_req  in  1  data request; held until d_gnt.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_WIDTH  data address.
- d_wdata  in  WORD_WIDTH  write data.
- d_gnt  out  1  data request accepted (1-cycle pulse).
- d_rvalid  out  1  data read data valid (1-cycle pulse, reads only).
- d_rdata  out  WORD_WIDTH  data read data.
- mem_read  out  1  to memory memRead.
- mem_write  out  1  to memory memWrite.
- mem_address  out  ADDR_WIDTH  to memory address.
- mem_data_in  out  WORD_WIDTH  to memory data_in.
- mem_data_out  in  WORD_WIDTH  from memory read data.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; mem_read, mem_write, gnt, rvalid=0.
  - mem_address=0, mem_data_in=0.
  - Priority pointer = I; wait counter = 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req, the round-robin winner gets its gnt asserted combinationally in this cycle.
  - Winner's addr/we/wdata and port id are latched; next state is ISSUE.
  - With no req, the FSM stays in IDLE.
- ISSUE (1 cycle):
  - mem_address and mem_data_in are driven from the latches.
  - Read: mem_read=1 only; next state is WAIT if RD_LATENCY>1, else RESP.
  - Write: mem_write=1 only; next state is IDLE; no rvalid.
- WAIT: counts RD_LATENCY-1 cycles, then goes to RESP.
- RESP (1 cycle):
  - The winning port's rvalid=1.
  - Its rdata = mem_data_out; next state is IDLE.
- Latency:
  - Read: gnt in cycle 0, mem_read in cycle 1, rvalid in cycle 1+RD_LATENCY.
  - Write: gnt in cycle 0, mem_write in cycle 1.
  - Minimum spacing between grants: 2 cycles (write), 2+RD_LATENCY (read).
- Arbitration:
  - A sole requester wins.
  - On simultaneous requests the pointer port wins; the pointer then moves to the loser.
  - The pointer updates only on a grant.
- Requests arriving outside IDLE see gnt=0 and must hold.
- A req dropped before gnt is legal and has no side effect.
- Latched values are immune to requester changes after gnt.
- Invariant: mem_read & mem_write is never 1. Both are 0 outside ISSUE.
- mem_address and mem_data_in hold their last value while idle.
- if_rdata and d_rdata are meaningful only while their rvalid is high.
- The fetch port never writes.
- Reset mid-transaction: the transaction is aborted, no rvalid is issued, and no memory strobe is driven after rst_n falls.

Decomposition:
- Package mem_arb_pkg holds:
  - state_t enum {IDLE, ISSUE, WAIT, RESP};
  - port_t enum {PORT_I, PORT_D};
  - default width constants.
- Sub-module rr_arb2: 2-way round-robin picker.
  - Inputs: req[1:0], pointer, advance.
  - Outputs: onehot grant, next pointer.
- FSM, latches and wait counter stay in mem_port_arbiter.

Test Plan:
- Fetch read: if_req=1, if_addr=0x0 after reset → if_gnt at cycle 0, mem_read=1 with mem_address=0x0 at cycle 1, if_rvalid at cycle 2 with if_rdata = memory word 0.
- Write then read back: d_we=1, d_addr=0x3, d_wdata=0x1 → mem_write=1 at cycle 1, no d_rvalid. Then d_we=0, d_addr=0x3 → d_rvalid with d_rdata=0x00000001.
- Contention: if_req and d_req both held high for 3 transactions → grant order I, D, I; the non-granted port sees gnt=0 while the FSM is busy.
- RD_LATENCY=3 build: data read to 0xA → d_rvalid exactly 4 cycles after d_gnt, and a single pulse.
- Reset mid-read: rst_n=0 in the WAIT state → all outputs 0 immediately; no rvalid afterwards; the next if_req is granted first (pointer=I).
- Invariant checker across random req/we/addr traffic with write data 0xFFFF → mem_read&mem_write never both 1, and each gnt yields exactly one ISSUE cycle.
